mem_access: RTL and testbench
=============================

# mem_access

Memory-access and flag-commit stage sitting directly downstream of the execution stage. It consumes the ALU result (`dst`), the store data (`sdata`) and the N/Z/V flags. It runs loads and stores against a data memory over a req/ack handshake, and stalls upstream while an access is outstanding. It then presents the writeback value and the committed flag register to the rest of the core.

## Interface
- `TIMEOUT`, 255: maximum WAIT cycles without `mem_ack` before the access is aborted (1..65535).
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `alu_res  in  16`: execution-stage result; the memory address for loads/stores.
- `sdata  in  16`: store data.
- `rd_en  in  1`: instruction is a load.
- `wr_en  in  1`: instruction is a store. Wins if asserted together with `rd_en`.
- `N`, `Z`, `V`  in  1 each: flags from the execution stage.
- `flag_we  in  1`: instruction updates flags.
- `mem_req  out  1`: memory request, held until acknowledged.
- `mem_we  out  1`: request is a write.
- `mem_addr  out  16`: registered address.
- `mem_wdata  out  16`: registered store data.
- `mem_rdata  in  16`: read data, valid in the `mem_ack` cycle.
- `mem_ack  in  1`: memory acknowledge, single-cycle pulse.
- `wb_data  out  16`: writeback value.
- `stall  out  1`: freezes upstream stages and the PC.
- `flag_n`, `flag_z`, `flag_v`  out  1 each: committed flag register.
- `mem_err  out  1`: sticky timeout error.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - If `rd_en|wr_en`, the next edge does the following: capture `mem_addr<=alu_res`, `mem_wdata<=sdata`, `mem_we<=wr_en`, set `mem_req<=1`, clear the timeout counter, and go to WAIT.
  - Otherwise stay in IDLE. `wb_data = alu_res`, combinational pass-through.
- **WAIT**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable.
  - On an edge with `mem_ack=1`: `mem_req<=0`, capture `rdata_q<=mem_rdata` (loads only), go to DONE.
  - Otherwise the counter increments. When the counter equals `TIMEOUT-1` with no ack: `mem_req<=0`, `rdata_q<=16'h0000`, `mem_err<=1`, go to DONE.
- **DONE**
  - `wb_data = rdata_q` for loads, `alu_res` for stores.
  - Go to IDLE unconditionally. Inputs are ignored, because the instruction still at the inputs is the one just completed.
- `stall = (IDLE & (rd_en|wr_en)) | WAIT`, combinational. It is 0 in DONE.
- Flags: `flag_n/z/v <= N/Z/V` on an edge where `flag_we & ~stall`, so an instruction commits its flags exactly once.
- An ack arriving in IDLE or DONE is ignored.
- `mem_err` clears only on reset.

## Timing
- Reset values:
  - state IDLE
  - `mem_req`, `mem_we` = 0
  - `mem_addr`, `mem_wdata`, `rdata_q` = 0
  - flags = 0
  - `mem_err` = 0
  - counter = 0
  - `stall` follows its equation (0 with no memory op present)
- Non-memory instruction: 0 added cycles.
- Memory instruction: 2 + k stall cycles, where k = WAIT cycles before ack. With ack in the first WAIT cycle: IDLE(stall) → WAIT(stall) → DONE = 3 cycles total.
- Timeout: DONE is entered after exactly `TIMEOUT` WAIT cycles.
- `mem_req` rises the cycle after IDLE detects the op. It falls the cycle after the ack/timeout edge.
- Reset mid-access: returns to IDLE immediately, `mem_req` drops asynchronously, the access is abandoned, `mem_err` clears.
- Counter is 16 bits; it never wraps because it is bounded by `TIMEOUT`.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE=2'd0, WAIT=2'd1, DONE=2'd2)
  - `MEM_TIMEOUT_DEF = 255`
  - `WB_ERR_DATA = 16'h0000`
- One sub-module, `flag_reg`: the 3-bit flag register with write enable and async active-low reset.

## Test plan
- Reset: with `rst_n=0`, all outputs are 0. After release with no ops, `wb_data` equals `alu_res` (apply 16'h1234 and expect 16'h1234), and `stall=0`.
- Load: `rd_en=1`, `alu_res=16'h0040`, ack in the first WAIT cycle with `mem_rdata=16'hBEEF`.
  - `stall` is high for 2 cycles.
  - `mem_addr=16'h0040` and `mem_we=0` throughout WAIT.
  - DONE shows `wb_data=16'hBEEF`.
- Store with slow memory: `wr_en=1`, `alu_res=16'h0100`, `sdata=16'hA5A5`, ack after 5 WAIT cycles. Expect `mem_we=1`, stable `mem_addr`/`mem_wdata`, and 6 stall cycles.
- Timeout: `TIMEOUT=4`, `rd_en=1`, no ack.
  - DONE is entered after 4 WAIT cycles.
  - `wb_data=16'h0000`.
  - `mem_err=1`, and it stays 1 across later normal accesses.
- Flags: a load with `flag_we=1`, N=1 Z=0 V=1. Flags remain 0 while stalled and become 1/0/1 at the DONE edge. A back-to-back ALU op with `flag_we=0` leaves them unchanged.
- Reset mid-WAIT: assert `rst_n=0` asynchronously. `mem_req` drops without waiting for a clock edge, the state returns to IDLE, and a later ack is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access / flag-commit stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned MEM_TIMEOUT_DEF = 32'd255;
    localparam logic [15:0] WB_ERR_DATA     = 16'h0000;
    localparam int unsigned DATA_W          = 32'd16;
    localparam int unsigned FLAG_W          = 32'd3;

    // An instruction touches memory when it is either a load or a store.
    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mem_access_flag_reg.sv
// Committed N/Z/V flag register with load enable.
module flag_reg
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [FLAG_W-1:0] d,
    output logic [FLAG_W-1:0] q
);

    // Flag storage: load on enable, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 3'b000;
        end else if (we) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: runs loads/stores over a req/ack handshake with a
// timeout, stalls upstream while busy, and commits flags once per instruction.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] sdata,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              N,
    input  logic              Z,
    input  logic              V,
    input  logic              flag_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v,
    output logic              mem_err
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

    state_e            state_r, state_s;
    logic              req_r, req_s;
    logic              we_r, we_s;
    logic [DATA_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic [15:0]       cnt_r, cnt_s;
    logic              err_r, err_s;
    logic              mem_op_s;
    logic              flag_wr_s;
    logic [FLAG_W-1:0] flags_s;

    assign mem_op_s = is_mem_op(rd_en, wr_en);

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 16'h0000;
            rdata_r <= 16'h0000;
            cnt_r   <= 16'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            req_r   <= req_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            rdata_r <= rdata_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

    // Next-state and next-datapath logic; everything holds unless a transition acts.
    always_comb begin
        state_s = state_r;
        req_s   = req_r;
        we_s    = we_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    addr_s  = alu_res;
                    wdata_s = sdata;
                    we_s    = wr_en;
                    req_s   = 1'b1;
                    cnt_s   = 16'd0;
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    req_s   = 1'b0;
                    state_s = DONE;
                    if (!we_r) begin
                        rdata_s = mem_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    req_s   = 1'b0;
                    rdata_s = WB_ERR_DATA;
                    err_s   = 1'b1;
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Stall covers the detect cycle and every WAIT cycle, never DONE.
    always_comb begin
        if (state_r == WAIT) begin
            stall = 1'b1;
        end else if (state_r == IDLE) begin
            stall = mem_op_s;
        end else begin
            stall = 1'b0;
        end
    end

    // Writeback: load data in DONE of a load, otherwise the ALU result.
    always_comb begin
        if ((state_r == DONE) && !we_r) begin
            wb_data = rdata_r;
        end else begin
            wb_data = alu_res;
        end
    end

    // Commit only on the unstalled edge so each instruction updates flags once.
    assign flag_wr_s = flag_we & ~stall;

    flag_reg u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (flag_wr_s),
        .d     ({N, Z, V}),
        .q     (flags_s)
    );

    assign flag_n    = flags_s[2];
    assign flag_z    = flags_s[1];
    assign flag_v    = flags_s[0];
    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_err   = err_r;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// instruction stream checked against a cycle-count / value reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] alu_res = 16'h0000, sdata = 16'h0000, mem_rdata = 16'h0000;
    logic        rd_a = 1'b0, wr_a = 1'b0, ack_a = 1'b0;
    logic        rd_b = 1'b0, wr_b = 1'b0, ack_b = 1'b0;
    logic        n_i = 1'b0, z_i = 1'b0, v_i = 1'b0, flag_we = 1'b0;

    logic        req_a, we_a, stall_a, fn_a, fz_a, fv_a, err_a;
    logic [15:0] addr_a, wdata_a, wb_a;
    logic        req_b, we_b, stall_b, fn_b, fz_b, fv_b, err_b;
    logic [15:0] addr_b, wdata_b, wb_b;

    int          errors = 0;
    int          checks = 0;
    bit          sel = 1'b0;
    logic [2:0]  exp_flags = 3'b000;

    logic        cur_req, cur_we, cur_stall;
    logic [15:0] cur_addr, cur_wdata, cur_wb;
    logic [2:0]  cur_flags;

    always #5 clk = ~clk;

    mem_access dut_a (
        .clk(clk), .rst_n(rst_n), .alu_res(alu_res), .sdata(sdata),
        .rd_en(rd_a), .wr_en(wr_a), .N(n_i), .Z(z_i), .V(v_i), .flag_we(flag_we),
        .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_rdata(mem_rdata), .mem_ack(ack_a), .wb_data(wb_a), .stall(stall_a),
        .flag_n(fn_a), .flag_z(fz_a), .flag_v(fv_a), .mem_err(err_a)
    );

    mem_access #(.TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .alu_res(alu_res), .sdata(sdata),
        .rd_en(rd_b), .wr_en(wr_b), .N(n_i), .Z(z_i), .V(v_i), .flag_we(flag_we),
        .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_rdata(mem_rdata), .mem_ack(ack_b), .wb_data(wb_b), .stall(stall_b),
        .flag_n(fn_b), .flag_z(fz_b), .flag_v(fv_b), .mem_err(err_b)
    );

    assign cur_req   = sel ? req_b   : req_a;
    assign cur_we    = sel ? we_b    : we_a;
    assign cur_stall = sel ? stall_b : stall_a;
    assign cur_addr  = sel ? addr_b  : addr_a;
    assign cur_wdata = sel ? wdata_b : wdata_a;
    assign cur_wb    = sel ? wb_b    : wb_a;
    assign cur_flags = sel ? {fn_b, fz_b, fv_b} : {fn_a, fz_a, fv_a};

    // Drives one memory instruction and reports what was observed; ack_cyc is the
    // 1-based WAIT cycle that gets the ack (0 = never).
    task automatic do_access(input bit use_b, input bit rd, input bit wr,
                             input logic [15:0] addr, input logic [15:0] wd,
                             input bit fwe, input logic [2:0] nzv,
                             input int ack_cyc, input logic [15:0] rdv,
                             output int stalls, output int nwait, output logic [15:0] wb,
                             output bit hold_ok, output bit fl_hold_ok,
                             output logic [2:0] fl_done, output logic [2:0] fl_after,
                             output bit finished);
        logic [2:0] fl0;
        sel = use_b;
        @(negedge clk);
        alu_res = addr; sdata = wd; {n_i, z_i, v_i} = nzv; flag_we = fwe;
        if (use_b) begin rd_b = rd; wr_b = wr; end
        else begin rd_a = rd; wr_a = wr; end
        #1;
        fl0 = cur_flags;
        stalls = 0; nwait = 0; hold_ok = 1'b1; fl_hold_ok = 1'b1;
        finished = 1'b0; wb = 16'h0000; fl_done = 3'b000;
        for (int c = 0; c < 600 && !finished; c++) begin
            mem_rdata = 16'($urandom);
            if (cur_stall) begin
                stalls++;
                if (cur_flags !== fl0) fl_hold_ok = 1'b0;
                if (cur_req) begin
                    nwait++;
                    if (cur_addr !== addr || cur_wdata !== wd || cur_we !== wr) hold_ok = 1'b0;
                    if (nwait == ack_cyc) begin
                        mem_rdata = rdv;
                        if (use_b) ack_b = 1'b1; else ack_a = 1'b1;
                    end
                end
            end else begin
                finished = 1'b1;
                wb = cur_wb;
                fl_done = cur_flags;
                rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
            end
            @(negedge clk);
            ack_a = 1'b0; ack_b = 1'b0;
            #1;
        end
        fl_after = cur_flags;
        flag_we = 1'b0;
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    endtask

    // One non-memory instruction on instance A.
    task automatic alu_step(input logic [15:0] val, input bit fwe, input logic [2:0] nzv,
                            output logic st, output logic [15:0] wb, output logic [2:0] fl_after);
        sel = 1'b0;
        @(negedge clk);
        alu_res = val; rd_a = 1'b0; wr_a = 1'b0; flag_we = fwe; {n_i, z_i, v_i} = nzv;
        #1;
        st = stall_a; wb = wb_a;
        @(negedge clk);
        flag_we = 1'b0;
        #1;
        fl_after = {fn_a, fz_a, fv_a};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({req_a, we_a, stall_a} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b expected 000", {req_a, we_a, stall_a}); end
        checks++; if ({addr_a, wdata_a, wb_a} !== 48'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {addr_a, wdata_a, wb_a}); end
        checks++; if ({fn_a, fz_a, fv_a, err_a, err_b} !== 5'b0) begin errors++; $display("FAIL reset_flags_err: got %b expected 00000", {fn_a, fz_a, fv_a, err_a, err_b}); end
        @(negedge clk);
        rst_n = 1'b1; alu_res = 16'h1234;
        #1;
        checks++; if (wb_a !== 16'h1234) begin errors++; $display("FAIL reset_passthru: got %h expected 1234", wb_a); end
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_a); end
    endtask

    task automatic test_flags();
        int st, nw; logic [15:0] wb; bit hok, fok, fin; logic [2:0] fd, fa; logic s;
        do_access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 3'b101, 1, 16'h5555,
                  st, nw, wb, hok, fok, fd, fa, fin);
        checks++; if (fok !== 1'b1) begin errors++; $display("FAIL flags_hold_stall: got %b expected 1", fok); end
        checks++; if (fd !== 3'b000) begin errors++; $display("FAIL flags_in_done: got %b expected 000", fd); end
        checks++; if (fa !== 3'b101) begin errors++; $display("FAIL flags_commit: got %b expected 101", fa); end
        exp_flags = 3'b101;
        alu_step(16'h7777, 1'b0, 3'b010, s, wb, fa);
        checks++; if (fa !== 3'b101) begin errors++; $display("FAIL flags_no_we: got %b expected 101", fa); end
        checks++; if (s !== 1'b0 || wb !== 16'h7777) begin errors++; $display("FAIL alu_b2b: got %b/%h expected 0/7777", s, wb); end
    endtask

    task automatic test_load();
        int st, nw; logic [15:0] wb; bit hok, fok, fin; logic [2:0] fd, fa;
        do_access(1'b0, 1'b1, 1'b0, 16'h0040, 16'h3C3C, 1'b0, 3'b000, 1, 16'hBEEF,
                  st, nw, wb, hok, fok, fd, fa, fin);
        checks++; if (fin !== 1'b1 || st != 2) begin errors++; $display("FAIL load_stall: got %0d (done=%b) expected 2", st, fin); end
        checks++; if (hok !== 1'b1) begin errors++; $display("FAIL load_hold: got %b expected 1", hok); end
        checks++; if (wb !== 16'hBEEF) begin errors++; $display("FAIL load_wb: got %h expected beef", wb); end
    endtask

    task automatic test_store_slow();
        int st, nw; logic [15:0] wb; bit hok, fok, fin; logic [2:0] fd, fa;
        do_access(1'b0, 1'b0, 1'b1, 16'h0100, 16'hA5A5, 1'b0, 3'b000, 5, 16'h1111,
                  st, nw, wb, hok, fok, fd, fa, fin);
        checks++; if (fin !== 1'b1 || st != 6) begin errors++; $display("FAIL store_stall: got %0d expected 6", st); end
        checks++; if (hok !== 1'b1) begin errors++; $display("FAIL store_hold: got %b expected 1", hok); end
        checks++; if (wb !== 16'h0100) begin errors++; $display("FAIL store_wb: got %h expected 0100", wb); end
    endtask

    task automatic test_both_en();
        int st, nw; logic [15:0] wb; bit hok, fok, fin; logic [2:0] fd, fa;
        do_access(1'b0, 1'b1, 1'b1, 16'h0222, 16'h5A5A, 1'b0, 3'b000, 2, 16'hDEAD,
                  st, nw, wb, hok, fok, fd, fa, fin);
        checks++; if (hok !== 1'b1 || wb !== 16'h0222 || st != 3) begin errors++; $display("FAIL both_en_store: got hold=%b wb=%h st=%0d expected 1/0222/3", hok, wb, st); end
    endtask

    task automatic test_random();
        int st, nw, k; logic [15:0] wb, a, d, r; bit hok, fok, fin, rd, wr, fwe;
        logic [2:0] fd, fa, nzv, exp_after; logic s;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); d = 16'($urandom); r = 16'($urandom);
            nzv = 3'($urandom); fwe = 1'($urandom);
            k = int'($urandom_range(6, 1));
            exp_after = fwe ? nzv : exp_flags;
            case ($urandom_range(3, 0))
                0: begin
                    alu_step(a, fwe, nzv, s, wb, fa);
                    checks++; if (s !== 1'b0 || wb !== a) begin errors++; $display("FAIL rnd_alu[%0d]: got %b/%h expected 0/%h", i, s, wb, a); end
                    checks++; if (fa !== exp_after) begin errors++; $display("FAIL rnd_alu_flags[%0d]: got %b expected %b", i, fa, exp_after); end
                end
                default: begin
                    rd = 1'($urandom); wr = ~rd | 1'($urandom);
                    do_access(1'b0, rd, wr, a, d, fwe, nzv, k, r, st, nw, wb, hok, fok, fd, fa, fin);
                    checks++; if (fin !== 1'b1 || st != k + 1 || hok !== 1'b1) begin errors++; $display("FAIL rnd_mem[%0d]: got st=%0d hold=%b expected %0d/1", i, st, hok, k + 1); end
                    checks++; if (wb !== (wr ? a : r)) begin errors++; $display("FAIL rnd_wb[%0d]: got %h expected %h", i, wb, wr ? a : r); end
                    checks++; if (fok !== 1'b1 || fd !== exp_flags || fa !== exp_after) begin errors++; $display("FAIL rnd_flags[%0d]: got %b/%b expected %b/%b", i, fd, fa, exp_flags, exp_after); end
                end
            endcase
            exp_flags = exp_after;
        end
    endtask

    task automatic test_ack_last_cycle();
        int st, nw; logic [15:0] wb; bit hok, fok, fin; logic [2:0] fd, fa;
        do_access(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 3'b000, 4, 16'h7A7A,
                  st, nw, wb, hok, fok, fd, fa, fin);
        checks++; if (wb !== 16'h7A7A || nw != 4) begin errors++; $display("FAIL ack_last: got wb=%h waits=%0d expected 7a7a/4", wb, nw); end
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL ack_last_err: got %b expected 0", err_b); end
    endtask

    task automatic test_timeout();
        int st, nw; logic [15:0] wb; bit hok, fok, fin; logic [2:0] fd, fa;
        do_access(1'b1, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 3'b000, 0, 16'h9999,
                  st, nw, wb, hok, fok, fd, fa, fin);
        checks++; if (fin !== 1'b1 || nw != 4 || st != 5) begin errors++; $display("FAIL timeout_len: got waits=%0d st=%0d expected 4/5", nw, st); end
        checks++; if (wb !== 16'h0000) begin errors++; $display("FAIL timeout_wb: got %h expected 0000", wb); end
        checks++; if (err_b !== 1'b1 || req_b !== 1'b0) begin errors++; $display("FAIL timeout_err: got err=%b req=%b expected 1/0", err_b, req_b); end
        do_access(1'b1, 1'b0, 1'b1, 16'h0500, 16'h4242, 1'b0, 3'b000, 2, 16'h0000,
                  st, nw, wb, hok, fok, fd, fa, fin);
        do_access(1'b1, 1'b1, 1'b0, 16'h0600, 16'h0000, 1'b0, 3'b000, 1, 16'h6161,
                  st, nw, wb, hok, fok, fd, fa, fin);
        checks++; if (wb !== 16'h6161) begin errors++; $display("FAIL post_timeout_load: got %h expected 6161", wb); end
        checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_b); end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        @(negedge clk);
        rd_a = 1'b1; alu_res = 16'h0200;
        @(negedge clk);
        rd_a = 1'b0;
        #1;
        checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL rstmid_wait: got req=%b expected 1", req_a); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req_a !== 1'b0 || stall_a !== 1'b0) begin errors++; $display("FAIL rstmid_async: got req=%b stall=%b expected 0/0", req_a, stall_a); end
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL rstmid_err_clr: got %b expected 0", err_b); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ack_a = 1'b1; mem_rdata = 16'hC0DE; alu_res = 16'h0ABC;
        @(negedge clk);
        ack_a = 1'b0;
        #1;
        checks++; if (req_a !== 1'b0 || stall_a !== 1'b0 || wb_a !== 16'h0ABC) begin errors++; $display("FAIL rstmid_ack_ignored: got req=%b stall=%b wb=%h expected 0/0/0abc", req_a, stall_a, wb_a); end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_load();
        test_store_slow();
        test_both_en();
        test_random();
        test_ack_last_cycle();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
